// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32 datapath: sequences one instruction
// at a time and drives every datapath enable and mux select from the current state.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       zero,
  input  logic       neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALRLINK, S_LUI
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  state_t state_q, state_d;

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub_sel);
    logic [2:0] ctl;
    ctl = 3'b000;
    case (f3)
      3'b000:  ctl = sub_sel ? 3'b001 : 3'b000;
      3'b111:  ctl = 3'b010;
      3'b110:  ctl = 3'b011;
      3'b010:  ctl = 3'b100;
      3'b100:  ctl = 3'b101;
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = S_FETCH;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 3'b000;
    ImmSrc     = 3'b000;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        IRWrite   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        // Branch/jump target is computed here and held in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_JAL) ? 3'b011 : 3'b010;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BR:        state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR;
          OP_LUI:       state_d = S_LUI;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (op == OP_SW) ? 3'b001 : 3'b000;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUControl = alu_dec(func3, func7[5]);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec(func3, 1'b0);
        state_d    = S_ALUWB;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        case (func3)
          3'b000:  PCWrite = zero;
          3'b001:  PCWrite = ~zero;
          3'b100:  PCWrite = neg;
          3'b101:  PCWrite = ~neg;
          default: PCWrite = 1'b0;
        endcase
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
        state_d   = S_JALRLINK;
      end
      S_JALRLINK: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
      end
      S_LUI: begin
        ImmSrc    = 3'b100;
        ResultSrc = 2'b11;
        RegWrite  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset silences every output so an aborted instruction cannot write anything.
    if (rst) begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = 3'b000;
      ImmSrc     = 3'b000;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// state by state and compares all outputs against hand-computed vectors.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op, func7;
  logic [2:0] func3;
  logic       zero, neg;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  int checks = 0;
  int failures = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .zero(zero), .neg(neg),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [17:0] outv;
  assign outv = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                 ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal};

  function automatic logic [17:0] e(input logic pcw, input logic adr, input logic mw,
                                    input logic irw, input logic rw, input logic [1:0] rs,
                                    input logic [1:0] sa, input logic [1:0] sb,
                                    input logic [2:0] ac, input logic [2:0] imm,
                                    input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, imm, ill};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [17:0] exp);
    #1;
    checks++;
    assert (outv === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, outv, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] fetch_v, dec_v;
    fetch_v = e(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,3'b000,0);
    dec_v   = e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,0);
    rst = 1'b1; op = 7'b0100011; func3 = 3'b010; func7 = 7'b0; zero = 1'b0; neg = 1'b0;
    cyc(); cyc();
    chk("reset_hold", 18'b0);

    // SW up to MEMWRITE, then reset for two cycles
    rst = 1'b0; chk("sw_fetch", fetch_v);
    cyc(); chk("sw_decode", dec_v);
    cyc(); chk("sw_memadr", e(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b001,0));
    cyc(); chk("sw_memwrite", e(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    rst = 1'b1; chk("rst_in_memwrite", 18'b0);
    cyc(); chk("rst_cycle2", 18'b0);
    cyc(); rst = 1'b0; chk("post_reset_fetch", fetch_v);

    // R-type sub
    op = 7'b0110011; func3 = 3'b000; func7 = 7'b0100000;
    cyc(); chk("r_decode", dec_v);
    cyc(); chk("r_execr_sub", e(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    func3 = 3'b111; chk("r_execr_and", e(0,0,0,0,0,2'b00,2'b10,2'b00,3'b010,3'b000,0));
    func3 = 3'b011; chk("r_execr_other", e(0,0,0,0,0,2'b00,2'b10,2'b00,3'b000,3'b000,0));
    cyc(); chk("r_aluwb", e(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    cyc(); chk("r_next_fetch", fetch_v);

    // I-ALU: func7[5] ignored
    op = 7'b0010011; func3 = 3'b000; func7 = 7'b0100000;
    cyc(); chk("i_decode", dec_v);
    cyc(); chk("i_execi_add", e(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
    func3 = 3'b100; chk("i_execi_xor", e(0,0,0,0,0,2'b00,2'b10,2'b01,3'b101,3'b000,0));
    func3 = 3'b110; chk("i_execi_or", e(0,0,0,0,0,2'b00,2'b10,2'b01,3'b011,3'b000,0));
    func3 = 3'b010; chk("i_execi_slt", e(0,0,0,0,0,2'b00,2'b10,2'b01,3'b100,3'b000,0));
    cyc(); chk("i_aluwb", e(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    cyc(); chk("i_next_fetch", fetch_v);

    // LW: 5 cycles
    op = 7'b0000011; func3 = 3'b010;
    cyc(); chk("lw_decode", dec_v);
    cyc(); chk("lw_memadr", e(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,3'b000,0));
    cyc(); chk("lw_memread", e(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    cyc(); chk("lw_memwb", e(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,3'b000,0));
    cyc(); chk("lw_next_fetch", fetch_v);

    // Branch: taken decision combinational on flags in BRANCH
    op = 7'b1100011; func3 = 3'b000; zero = 1'b1;
    cyc(); chk("br_decode", dec_v);
    cyc(); chk("beq_taken", e(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    zero = 1'b0; chk("beq_not_taken", e(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    func3 = 3'b001; chk("bne_taken", e(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    zero = 1'b1; chk("bne_not_taken", e(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    func3 = 3'b100; neg = 1'b1; chk("blt_taken", e(1,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    func3 = 3'b101; chk("bge_not_taken", e(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    func3 = 3'b010; zero = 1'b0; neg = 1'b0;
    chk("br_bad_func3", e(0,0,0,0,0,2'b00,2'b10,2'b00,3'b001,3'b000,0));
    cyc(); chk("br_next_fetch", fetch_v);

    // JALR
    op = 7'b1100111; func3 = 3'b000;
    cyc(); chk("jalr_decode", dec_v);
    cyc(); chk("jalr_target", e(1,0,0,0,0,2'b10,2'b10,2'b01,3'b000,3'b000,0));
    cyc(); chk("jalr_link", e(0,0,0,0,1,2'b10,2'b01,2'b10,3'b000,3'b000,0));
    cyc(); chk("jalr_next_fetch", fetch_v);

    // JAL
    op = 7'b1101111;
    cyc(); chk("jal_decode", e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b011,0));
    cyc(); chk("jal_state", e(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,3'b000,0));
    cyc(); chk("jal_aluwb", e(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000,0));
    cyc(); chk("jal_next_fetch", fetch_v);

    // LUI
    op = 7'b0110111;
    cyc(); chk("lui_decode", dec_v);
    cyc(); chk("lui_state", e(0,0,0,0,1,2'b11,2'b00,2'b00,3'b000,3'b100,0));
    cyc(); chk("lui_next_fetch", fetch_v);

    // Illegal op
    op = 7'b1111111;
    cyc(); chk("illegal_decode", e(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,3'b010,1));
    cyc(); chk("illegal_next_fetch", fetch_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32 datapath.
- Decodes op/func3/func7 from the instruction register, plus zero/neg ALU flags.
- Drives every datapath enable and mux select, one instruction at a time.
- Sequences fetch, decode, execute, memory and writeback states.
- Sits beside the datapath in the CPU top level; no handshake with memory (single-cycle memory access).

Parameters:
None (all encodings fixed below).

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
op  in  7  Instr[6:0]
func3  in  3  Instr[14:12]
func7  in  7  Instr[31:25]
zero  in  1  ALU result == 0
neg  in  1  ALU result negative
PCWrite  out  1  PC register enable
AdrSrc  out  1  0=PC, 1=Result
MemWrite  out  1  memory write enable
IRWrite  out  1  IR/OldPC enable
RegWrite  out  1  register file write enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
ALUSrcA  out  2  00=PC, 01=OldPC, 10=A
ALUSrcB  out  2  00=B, 01=ImmExt, 10=4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
illegal  out  1  one-cycle pulse in DECODE on unsupported op

Behaviour:
- State register updates only on the rising clk edge.
- rst=1: next state FETCH. While rst=1, all outputs are 0 regardless of state.
- Outputs are combinational from the state, plus op/func3/func7/zero/neg where stated. Unlisted outputs are 0.
- ALUControl defaults to add.
- Supported ops: R 0110011, I-ALU 0010011, LW 0000011, SW 0100011, BR 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add; ImmSrc=J if op==JAL else B (target latched in ALUOut).
  - Next: LW/SW->MEMADR, R->EXECR, I-ALU->EXECI, BR->BRANCH, JAL->JAL, JALR->JALR, LUI->LUI.
  - Any other op: illegal=1, next FETCH (treated as NOP).
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc=S if SW else I. Next: MEMREAD (LW) or MEMWRITE (SW).
- MEMREAD: AdrSrc=1, ResultSrc=00. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. Next: FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl from func3/func7. Next: ALUWB.
  - 000 with func7[5]=0 -> add; 000 with func7[5]=1 -> sub.
  - 111 and, 110 or, 010 slt, 100 xor; other func3 -> add.
- EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, same func3 map; func7 ignored (000 always add). Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. Next: FETCH.
  - PCWrite = taken: func3 000 zero, 001 ~zero, 100 neg, 101 ~neg; other func3 -> not taken.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next: ALUWB (writes OldPC+4).
- JALR: ALUSrcA=10, ALUSrcB=01, ImmSrc=I, add, ResultSrc=10, PCWrite=1. Next: JALRLINK.
- JALRLINK: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1. Next: FETCH.
- LUI: ImmSrc=U, ResultSrc=11, RegWrite=1. Next: FETCH.
- Cycle counts (FETCH to next FETCH): R/I/SW/JAL/JALR = 4, LW = 5, BR/LUI = 3, illegal = 2.
- At most one of MemWrite/RegWrite is high in any cycle; PCWrite and RegWrite are never both high.
- Reset mid-instruction: the instruction is aborted. No write enable is high during the reset cycle; FETCH follows.
- No unreachable state may hang: any illegal state encoding goes to FETCH.

Test Plan:
- Reset: rst=1 for 2 cycles in MEMWRITE -> all outputs 0 during reset; first cycle after shows IRWrite=1, PCWrite=1, ALUSrcB=10.
- R sub: op=0110011, func3=000, func7=0100000 -> EXECR shows ALUControl=001, ALUSrcA=10, ALUSrcB=00; RegWrite=1 in cycle 4 only.
- LW: op=0000011 -> 5 cycles; MEMREAD AdrSrc=1; MEMWB ResultSrc=01, RegWrite=1; MemWrite never asserted.
- BEQ/BNE: func3=000 with zero=1 -> PCWrite=1 in cycle 3; zero=0 -> PCWrite=0. func3=001 inverts both results.
- JALR: op=1100111 -> cycle 3 PCWrite=1, ResultSrc=10; cycle 4 RegWrite=1, ALUSrcA=01, ALUSrcB=10; then FETCH.
- Illegal op=1111111 -> illegal=1 for one cycle in DECODE, no write enables, FETCH on the next cycle.
